mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the Olivia fetch stage (IF) and the LDUR/STUR data path (D).
//  - Sits between the core and the memory model.
//  - Registers each granted request and issues one memory access at a time.
//  - Times the fixed read latency and returns data/acks to the owning requester.
//  - D has priority over IF; a starvation guard bounds how long IF can wait.
// PARAMETERS
//  XLEN          64  address/data width in bits
//  MEM_LATENCY   2   cycles from mem_en to valid mem_rdata (must be >=1)
//  STARVE_LIMIT  4   consecutive D grants while IF waits before IF is forced to win (must be >=1)
// PORTS
//  CLK         in   1     clock, rising edge
//  RST         in   1     synchronous, active-low reset
//  if_req      in   1     fetch request; held with if_addr until if_gnt
//  if_addr     in   XLEN  fetch byte address
//  if_gnt      out  1     1-cycle pulse: IF request accepted
//  if_rvalid   out  1     1-cycle pulse: if_rdata valid
//  if_rdata    out  32    instruction word (mem_rdata[31:0])
//  d_req       in   1     data request; held with d_we/d_addr/d_wdata until d_gnt
//  d_we        in   1     1 = STUR (write), 0 = LDUR (read)
//  d_addr      in   XLEN  data byte address
//  d_wdata     in   XLEN  store data
//  d_gnt       out  1     1-cycle pulse: D request accepted
//  d_rvalid    out  1     1-cycle pulse: load data valid, or store complete
//  d_rdata     out  XLEN  load data (mem_rdata)
//  mem_en      out  1     memory access strobe, 1 cycle per transaction
//  mem_we      out  1     write enable, qualified by mem_en
//  mem_addr    out  XLEN  registered address of the granted request
//  mem_wdata   out  XLEN  registered store data
//  mem_rdata   in   XLEN  memory read data, valid MEM_LATENCY cycles after mem_en
// BEHAVIOUR
//  Reset (RST==0 at posedge):
//  - State IDLE; latency counter = 0; d_streak = 0.
//  - All outputs 0: gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata.
//  - Any in-flight transaction is dropped. A late mem_rdata is ignored and produces no rvalid.
//  FSM states: IDLE, BUSY_I, BUSY_D.
//  Arbitration is evaluated in IDLE, and also in the final BUSY cycle (the rvalid cycle).
//  - Winner selection: if d_req && !(if_req && d_streak==STARVE_LIMIT), D wins; else if if_req, IF wins.
//  - Winner state is entered at the next edge.
//  On entering BUSY_x (cycle G):
//  - x_gnt=1 and mem_en=1 for exactly one cycle.
//  - mem_addr/mem_we/mem_wdata are latched from the winner. mem_we=0 for IF.
//  - Counter is loaded with MEM_LATENCY.
//  At cycle G+MEM_LATENCY, x_rvalid=1 for one cycle and x_rdata = mem_rdata (combinational pass-through).
//  - Then go to IDLE, or directly to the next winner's BUSY state.
//  Stores also complete at G+MEM_LATENCY (d_rvalid is the write acknowledge; d_rdata don't-care).
//  Throughput: back-to-back grants every MEM_LATENCY+1 cycles. Request-to-grant latency is 1 cycle when idle.
//  d_streak rules:
//  - +1 on each D grant while if_req==1, saturating at STARVE_LIMIT.
//  - Cleared on any IF grant, or when if_req==0.
//  Boundaries:
//  - Both requesting from IDLE: D wins unless starved.
//  - A request dropped before its gnt is never issued (no gnt).
//  - rdata/rvalid of the inactive requester stay 0.
//  - mem_addr/mem_wdata hold their last value between transactions.
//  - Arithmetic: counter is $clog2(MEM_LATENCY+1) bits; d_streak is $clog2(STARVE_LIMIT+1) bits. No wrap allowed.
// STRUCTURE
//  olivia_pkg:
//  - State encodings (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D).
//  - XLEN constant shared with the register file, ALU and data memory.
//  Single module, no sub-modules. The latency counter and starvation counter are inline always blocks.
// TESTING (MEM_LATENCY=2, STARVE_LIMIT=4)
//  1. Hold RST=0 for 2 cycles, release, no requests -> all outputs 0, mem_en never asserted.
//  2. if_req, if_addr=8 at cycle 0 -> if_gnt and mem_en at cycle 1 with mem_addr=8, mem_we=0;
//     if_rvalid at cycle 3 with if_rdata = mem_rdata[31:0].
//  3. STUR: d_req, d_we=1, d_addr=16, d_wdata=0x2A -> d_gnt, mem_en, mem_we=1, mem_wdata=0x2A at cycle 1;
//     d_rvalid at cycle 3.
//  4. if_req and d_req rise together, both held continuously ->
//     - D granted 4 times at cycles 1,4,7,10;
//     - IF granted at cycle 13;
//     - d_streak back to 0.
//  5. RST pulled low the cycle after d_gnt -> no d_rvalid ever; all outputs 0 next cycle;
//     after release, fresh d_req is granted in 1 cycle.
//  6. if_req raised then dropped while D is BUSY -> no if_gnt issued; memory sees only the D access.

Source files
------------

// File: rtl/olivia_pkg.sv
// olivia_pkg: constants shared across the Olivia core slice.
// Holds the machine word width and the memory-port arbiter state encodings.
`default_nettype none

package olivia_pkg;

    localparam int XLEN        = 64;
    localparam int ARB_STATE_W = 2;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_BUSY_I = 2'd1;
    localparam logic [1:0] ARB_BUSY_D = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch (IF) and data (D),
// one access in flight at a time, D priority with a starvation guard for IF.
`default_nettype none

module mem_port_arbiter
    import olivia_pkg::*;
#(
    parameter int XLEN         = olivia_pkg::XLEN,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [31:0]     if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(MEM_LATENCY);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    logic [ARB_STATE_W-1:0] state;
    logic [CNT_W-1:0]       cnt;
    logic [STREAK_W-1:0]    d_streak;
    logic                   we_latched;

    logic arb;
    logic d_win;
    logic if_win;
    logic busy_i;
    logic busy_d;

    assign busy_i = (state == ARB_BUSY_I);
    assign busy_d = (state == ARB_BUSY_D);

    // The counter sits at zero in IDLE and in the last BUSY cycle, so both arbitrate.
    assign arb    = (state == ARB_IDLE) || (cnt == '0);
    assign d_win  = d_req && !(if_req && (d_streak == STREAK_MAX));
    assign if_win = if_req && !d_win;

    // The counter holds its load value only in the first BUSY cycle.
    assign if_gnt    = busy_i && (cnt == LAT_LOAD);
    assign d_gnt     = busy_d && (cnt == LAT_LOAD);
    assign mem_en    = if_gnt || d_gnt;
    assign mem_we    = mem_en && we_latched;

    assign if_rvalid = busy_i && (cnt == '0);
    assign d_rvalid  = busy_d && (cnt == '0);
    assign if_rdata  = if_rvalid ? mem_rdata[31:0] : 32'd0;
    assign d_rdata   = d_rvalid  ? mem_rdata       : '0;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= ARB_IDLE;
            we_latched <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (arb) begin
            if (d_win) begin
                state      <= ARB_BUSY_D;
                we_latched <= d_we;
                mem_addr   <= d_addr;
                mem_wdata  <= d_wdata;
            end else if (if_win) begin
                state      <= ARB_BUSY_I;
                we_latched <= 1'b0;
                mem_addr   <= if_addr;
            end else begin
                state      <= ARB_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt <= '0;
        end else if (arb) begin
            cnt <= (d_win || if_win) ? LAT_LOAD : '0;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Counts D grants that overtook a waiting IF; saturates so it never wraps.
    always_ff @(posedge CLK) begin
        if (!RST || !if_req) begin
            d_streak <= '0;
        end else if (arb && d_win) begin
            if (d_streak != STREAK_MAX) begin
                d_streak <= d_streak + STREAK_W'(1);
            end
        end else if (arb && if_win) begin
            d_streak <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
// (MEM_LATENCY=2, STARVE_LIMIT=4).
`default_nettype none

module tb_mem_port_arbiter;

    logic        CLK;
    logic        RST;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int total;
    int passed;

    mem_port_arbiter #(
        .XLEN         (64),
        .MEM_LATENCY  (2),
        .STARVE_LIMIT (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        RST = 1'b0;
        step();
        step();
        flags = {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, 2'b00};
        total++;
        if (flags !== 8'd0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0 || if_rdata !== 32'd0 || d_rdata !== 64'd0)
            $display("FAIL reset_outputs flags=%b addr=%h wdata=%h expected all zero", flags, mem_addr, mem_wdata);
        else passed++;
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (mem_en !== 1'b0 || if_gnt !== 1'b0 || d_gnt !== 1'b0)
                $display("FAIL idle_no_mem_en cycle=%0d mem_en=%b expected 0", i, mem_en);
            else passed++;
        end
    endtask

    task automatic test_if_read();
        mem_rdata = 64'hDEAD_BEEF_1234_5678;
        if_req  = 1'b1;
        if_addr = 64'd8;
        step();
        total++;
        if (if_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 64'd8 || mem_we !== 1'b0 || d_gnt !== 1'b0)
            $display("FAIL if_grant gnt=%b en=%b addr=%h we=%b expected 1 1 8 0", if_gnt, mem_en, mem_addr, mem_we);
        else passed++;
        if_req = 1'b0;
        step();
        total++;
        if (if_gnt !== 1'b0 || mem_en !== 1'b0 || if_rvalid !== 1'b0)
            $display("FAIL if_wait gnt=%b en=%b rvalid=%b expected 0 0 0", if_gnt, mem_en, if_rvalid);
        else passed++;
        step();
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h1234_5678 || d_rvalid !== 1'b0 || d_rdata !== 64'd0)
            $display("FAIL if_rvalid rvalid=%b rdata=%h d_rvalid=%b expected 1 12345678 0", if_rvalid, if_rdata, d_rvalid);
        else passed++;
        step();
        total++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'd0 || mem_en !== 1'b0)
            $display("FAIL if_after rvalid=%b rdata=%h en=%b expected 0 0 0", if_rvalid, if_rdata, mem_en);
        else passed++;
    endtask

    task automatic test_store();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 64'd16;
        d_wdata = 64'h2A;
        step();
        total++;
        if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'd16 || mem_wdata !== 64'h2A)
            $display("FAIL store_grant gnt=%b en=%b we=%b addr=%h wdata=%h expected 1 1 1 10 2a",
                     d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        else passed++;
        d_req = 1'b0;
        d_we  = 1'b0;
        step();
        step();
        total++;
        if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || mem_en !== 1'b0)
            $display("FAIL store_ack d_rvalid=%b if_rvalid=%b en=%b expected 1 0 0", d_rvalid, if_rvalid, mem_en);
        else passed++;
        step();
        total++;
        if (d_rvalid !== 1'b0 || mem_addr !== 64'd16 || mem_wdata !== 64'h2A || mem_we !== 1'b0)
            $display("FAIL store_hold rvalid=%b addr=%h wdata=%h we=%b expected 0 10 2a 0", d_rvalid, mem_addr, mem_wdata, mem_we);
        else passed++;
    endtask

    task automatic test_starvation();
        logic exp_d;
        logic exp_i;
        if_req  = 1'b1;
        if_addr = 64'h100;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 64'h200;
        for (int c = 1; c <= 28; c++) begin
            step();
            exp_d = (c == 1 || c == 4 || c == 7 || c == 10 || c == 16 || c == 19 || c == 22 || c == 25);
            exp_i = (c == 13 || c == 28);
            total++;
            if (d_gnt !== exp_d || if_gnt !== exp_i)
                $display("FAIL starve_grants cycle=%0d d_gnt=%b if_gnt=%b expected %b %b", c, d_gnt, if_gnt, exp_d, exp_i);
            else passed++;
            if (c == 13) begin
                total++;
                if (mem_addr !== 64'h100 || mem_we !== 1'b0)
                    $display("FAIL starve_if_addr addr=%h we=%b expected 100 0", mem_addr, mem_we);
                else passed++;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_reset_inflight();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 64'h40;
        step();
        total++;
        if (d_gnt !== 1'b1)
            $display("FAIL rst_flight_grant d_gnt=%b expected 1", d_gnt);
        else passed++;
        d_req = 1'b0;
        step();
        RST = 1'b0;
        step();
        total++;
        if (d_rvalid !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0)
            $display("FAIL rst_flight_zero rvalid=%b en=%b addr=%h wdata=%h expected all zero", d_rvalid, mem_en, mem_addr, mem_wdata);
        else passed++;
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (d_rvalid !== 1'b0 || mem_en !== 1'b0)
                $display("FAIL rst_flight_late cycle=%0d rvalid=%b en=%b expected 0 0", i, d_rvalid, mem_en);
            else passed++;
        end
        d_req  = 1'b1;
        d_addr = 64'h48;
        step();
        total++;
        if (d_gnt !== 1'b1 || mem_addr !== 64'h48)
            $display("FAIL rst_fresh_grant d_gnt=%b addr=%h expected 1 48", d_gnt, mem_addr);
        else passed++;
        d_req = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_dropped_if();
        int en_count;
        int if_gnt_count;
        en_count     = 0;
        if_gnt_count = 0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 64'h80;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (mem_en === 1'b1) en_count++;
            if (if_gnt === 1'b1) if_gnt_count++;
            if (c == 1) begin
                d_req   = 1'b0;
                if_req  = 1'b1;
                if_addr = 64'h300;
            end
            if (c == 2) if_req = 1'b0;
            if (c == 3) begin
                total++;
                if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0)
                    $display("FAIL drop_d_rvalid d_rvalid=%b if_rvalid=%b expected 1 0", d_rvalid, if_rvalid);
                else passed++;
            end
        end
        total++;
        if (if_gnt_count !== 0)
            $display("FAIL drop_no_if_gnt count=%0d expected 0", if_gnt_count);
        else passed++;
        total++;
        if (en_count !== 1 || mem_addr !== 64'h80)
            $display("FAIL drop_one_access count=%0d addr=%h expected 1 80", en_count, mem_addr);
        else passed++;
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        RST       = 1'b0;
        if_req    = 1'b0;
        if_addr   = 64'd0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 64'd0;
        d_wdata   = 64'd0;
        mem_rdata = 64'd0;
        test_reset();
        test_if_read();
        test_store();
        test_starvation();
        test_reset_inflight();
        test_dropped_if();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
